// File: rtl/uds_odata_drain.sv
// uds_odata_drain
// Double-buffered drain for the UDS engine's wide output tile. Each accepted
// tile is emitted as a sequence of SEG_W-bit beats over a valid/ready
// handshake. An upsample tile yields all segments. A downsample tile yields
// only the leading segments that carry data.
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   in_data[4*A*16]   wide tile, segment k at [k*SEG_W +: SEG_W]
//   in_valid          in_data holds a tile this cycle
//   in_mode[2]        function mode; bit1=1 upsample, bit1=0 downsample
//   in_ready          a free tile buffer exists (registered state only)
//   out_data[SEG_W]   current segment
//   out_valid/ready   output handshake
//   out_last          current beat is the final segment of its tile
//   out_idx[5]        segment index of the current beat
//   ovf, ovf_cnt[8]   sticky overflow flag, saturating drop count
//   clr_ovf           synchronous clear of ovf/ovf_cnt (a drop wins)
module uds_odata_drain #(
  parameter int A     = 64,
  parameter int SEG_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*A*16-1:0]   in_data,
  input  logic                in_valid,
  input  logic [1:0]          in_mode,
  output logic                in_ready,
  output logic [SEG_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [4:0]          out_idx,
  output logic                ovf,
  output logic [7:0]          ovf_cnt,
  input  logic                clr_ovf
);

  localparam int TILE_W  = 4 * A * 16;
  localparam int NSEG_UP = TILE_W / SEG_W;
  localparam int NSEG_DN = (A * 16) / (2 * SEG_W);

  localparam logic [5:0] NSEG_UP_L = 6'(NSEG_UP);
  localparam logic [5:0] NSEG_DN_L = 6'(NSEG_DN);

  // Tiles are stored segment-addressable; the packing matches in_data.
  logic [NSEG_UP-1:0][SEG_W-1:0] tile0_q, tile1_q;
  logic [5:0]                    nseg0_q, nseg1_q;

  logic [1:0] full_q, full_d;
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic [4:0] seg_q, seg_d;
  logic       ovf_q, ovf_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  logic                          accept, drop, fire;
  logic [5:0]                    nseg_new;
  logic [5:0]                    rd_nseg;
  logic [NSEG_UP-1:0][SEG_W-1:0] rd_tile;
  logic                          last_hit;
  logic                          unused_mode;

  assign unused_mode = in_mode[0];

  assign in_ready = ~full_q[wp_q];
  assign accept   = in_valid & in_ready;
  assign drop     = in_valid & ~in_ready;
  assign nseg_new = in_mode[1] ? NSEG_UP_L : NSEG_DN_L;

  assign rd_tile  = rp_q ? tile1_q : tile0_q;
  assign rd_nseg  = rp_q ? nseg1_q : nseg0_q;
  assign last_hit = ({1'b0, seg_q} == (rd_nseg - 6'd1));

  assign out_valid = full_q[rp_q];
  assign out_last  = out_valid & last_hit;
  assign out_idx   = seg_q;
  // Gated so the output reads zero whenever no tile is presented (incl. reset).
  assign out_data  = out_valid ? rd_tile[seg_q] : '0;
  assign fire      = out_valid & out_ready;

  assign ovf     = ovf_q;
  assign ovf_cnt = ovf_cnt_q;

  // Accept and release never target the same buffer: accept needs full[wp]=0,
  // release needs full[rp]=1, so both updates can be applied independently.
  always_comb begin
    full_d    = full_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    seg_d     = seg_q;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;

    if (accept) begin
      full_d[wp_q] = 1'b1;
      wp_d         = ~wp_q;
    end

    if (fire) begin
      if (last_hit) begin
        full_d[rp_q] = 1'b0;
        rp_d         = ~rp_q;
        seg_d        = '0;
      end else begin
        seg_d = seg_q + 5'd1;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf) begin
        ovf_cnt_d = 8'd1;
      end else if (ovf_cnt_q != '1) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      seg_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      full_q    <= full_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      seg_q     <= seg_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Buffer payload carries no reset; it is only written into an empty buffer.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wp_q) begin
        tile1_q <= in_data;
        nseg1_q <= nseg_new;
      end else begin
        tile0_q <= in_data;
        nseg0_q <= nseg_new;
      end
    end
  end

endmodule

// File: tb/tb_uds_odata_drain.sv
// Testbench for uds_odata_drain: table of tile transactions plus hand-written
// sequences for back-pressure, overflow saturation and mid-drain reset.
// A negedge monitor keeps a buffer-occupancy model and a beat scoreboard.
module tb_uds_odata_drain;

  localparam int A     = 64;
  localparam int SEG_W = 128;
  localparam int TW    = 4 * A * 16;
  localparam int NS    = TW / SEG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [TW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic [1:0]       in_mode = 2'b00;
  logic             in_ready;
  logic [SEG_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic [4:0]       out_idx;
  logic             ovf;
  logic [7:0]       ovf_cnt;
  logic             clr_ovf = 1'b0;

  uds_odata_drain #(.A(A), .SEG_W(SEG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .out_idx  (out_idx),
    .ovf      (ovf),
    .ovf_cnt  (ovf_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEG_W-1:0] data;
    logic [4:0]       idx;
    logic             last;
  } beat_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] base;
    bit          toggle;
    int          exp_beats;
  } vec_t;

  beat_t       sbq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          occ = 0;
  int          beats_seen = 0;
  logic        exp_ovf = 1'b0;
  logic [7:0]  exp_cnt = '0;
  logic [15:0] cur_base = '0;
  beat_t       held;
  bit          held_v = 1'b0;

  function automatic logic [TW-1:0] make_tile(input logic [15:0] base);
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < NS; k++) t[k*SEG_W +: SEG_W] = {8{base + 16'(k)}};
    return t;
  endfunction

  task automatic check(input string name, input logic [SEG_W-1:0] act,
                       input logic [SEG_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor and reference model, sampled away from the active edge.
  always @(negedge clk) begin : mon
    bit    acc, drp, rel;
    beat_t e, b;
    int    n;
    if (rst) begin
      sbq.delete();
      occ     = 0;
      exp_ovf = 1'b0;
      exp_cnt = '0;
      held_v  = 1'b0;
    end else begin
      rel = 1'b0;
      acc = in_valid && (occ < 2);
      drp = in_valid && (occ >= 2);
      check("in_ready", in_ready, occ < 2);
      check("out_valid", out_valid, occ > 0);
      check("ovf", ovf, exp_ovf);
      check("ovf_cnt", ovf_cnt, exp_cnt);
      if (out_valid) begin
        b.data = out_data;
        b.idx  = out_idx;
        b.last = out_last;
        if (held_v) begin
          check("held_data", b.data, held.data);
          check("held_idx", b.idx, held.idx);
          check("held_last", b.last, held.last);
        end
        if (out_ready) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
          end else begin
            e = sbq.pop_front();
            check("beat_data", b.data, e.data);
            check("beat_idx", b.idx, e.idx);
            check("beat_last", b.last, e.last);
            rel = e.last;
          end
          beats_seen++;
          held_v = 1'b0;
        end else begin
          held   = b;
          held_v = 1'b1;
        end
      end else begin
        check("idle_last", out_last, 1'b0);
        held_v = 1'b0;
      end
      if (acc) begin
        n = in_mode[1] ? 32 : 4;
        for (int k = 0; k < n; k++) begin
          e.data = {8{cur_base + 16'(k)}};
          e.idx  = 5'(k);
          e.last = (k == n - 1);
          sbq.push_back(e);
        end
      end
      if (drp) begin
        exp_ovf = 1'b1;
        exp_cnt = clr_ovf ? 8'd1 : ((exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1);
      end else if (clr_ovf) begin
        exp_ovf = 1'b0;
        exp_cnt = '0;
      end
      occ = occ + (acc ? 1 : 0) - (rel ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic [1:0] mode, input logic [15:0] base);
    cur_base = base;
    in_data  = make_tile(base);
    in_mode  = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit toggle, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sbq.size() == 0 && occ == 0) begin
        done = 1'b1;
        break;
      end
      tick();
      if (toggle) out_ready = ~out_ready;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sbq.size());
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  vec_t vecs[4];
  bit   hit;

  initial begin
    vecs[0] = '{mode: 2'b10, base: 16'h0100, toggle: 1'b0, exp_beats: 32};
    vecs[1] = '{mode: 2'b00, base: 16'h0200, toggle: 1'b0, exp_beats: 4};
    vecs[2] = '{mode: 2'b11, base: 16'h0300, toggle: 1'b1, exp_beats: 32};
    vecs[3] = '{mode: 2'b01, base: 16'h0400, toggle: 1'b1, exp_beats: 4};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_idx", out_idx, 5'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_ovf_cnt", ovf_cnt, 8'd0);
    rst = 1'b0;
    tick();

    // Table of single-tile transactions.
    foreach (vecs[i]) begin
      beats_seen = 0;
      out_ready  = 1'b1;
      send_tile(vecs[i].mode, vecs[i].base);
      check("first_valid", out_valid, 1'b1);
      check("first_idx", out_idx, 5'd0);
      wait_drain(vecs[i].toggle, 300);
      check("beat_count", beats_seen, vecs[i].exp_beats);
    end

    // Back-pressure: three tiles on consecutive cycles, third one dropped.
    beats_seen = 0;
    out_ready  = 1'b0;
    cur_base = 16'h0700; in_data = make_tile(16'h0700); in_mode = 2'b10; in_valid = 1'b1;
    tick();
    cur_base = 16'h0800; in_data = make_tile(16'h0800); in_mode = 2'b00;
    tick();
    cur_base = 16'h0900; in_data = make_tile(16'h0900); in_mode = 2'b00;
    tick();
    in_valid = 1'b0;
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_ovf", ovf, 1'b1);
    check("bp_ovf_cnt", ovf_cnt, 8'd1);
    out_ready = 1'b1;
    wait_drain(1'b0, 300);
    check("bp_beat_count", beats_seen, 36);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("bp_clr_ovf", ovf, 1'b0);

    // Saturation of the drop count, clear, and drop-over-clear priority.
    beats_seen = 0;
    out_ready  = 1'b0;
    send_tile(2'b00, 16'h0A00);
    send_tile(2'b00, 16'h0B00);
    in_valid = 1'b1;
    repeat (260) tick();
    in_valid = 1'b0;
    check("sat_ovf", ovf, 1'b1);
    check("sat_ovf_cnt", ovf_cnt, 8'd255);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", ovf, 1'b0);
    check("clr_ovf_cnt", ovf_cnt, 8'd0);
    in_valid = 1'b1;
    clr_ovf  = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    check("prio_ovf", ovf, 1'b1);
    check("prio_ovf_cnt", ovf_cnt, 8'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    out_ready = 1'b1;
    wait_drain(1'b0, 300);
    check("sat_beat_count", beats_seen, 8);

    // Reset in the middle of an upsample drain.
    beats_seen = 0;
    out_ready  = 1'b1;
    send_tile(2'b10, 16'h0C00);
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (out_valid && out_idx == 5'd10) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check("rst_reach_idx10", hit, 1'b1);
    check("rst_beats_before", beats_seen, 10);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_last", out_last, 1'b0);
    check("midrst_out_idx", out_idx, 5'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("postrst_idle", out_valid, 1'b0);
    end
    beats_seen = 0;
    send_tile(2'b00, 16'h0D00);
    check("postrst_first_idx", out_idx, 5'd0);
    wait_drain(1'b0, 100);
    check("postrst_beat_count", beats_seen, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uds_odata_drain.md
UDS_ODATA_DRAIN -- requirements
Module: uds_odata_drain

Interface
REQ-001 SHALL have parameter A, default 64, meaning items per UDS input tile (16-bit items).
REQ-002 SHALL have parameter SEG_W, default 128, meaning output beat width in bits (8 items).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-005 SHALL have port in_data, input, 4*A*16, the wide tile from the UDS engine's odata; segment k is bits [k*SEG_W +: SEG_W].
REQ-006 SHALL have port in_valid, input, 1, meaning in_data holds a tile this cycle (the UDS engine's odata_valid).
REQ-007 SHALL have port in_mode, input, 2, meaning the UDS engine's function_mode: bit1=1 is upsample, bit1=0 is downsample.
REQ-008 SHALL have port in_ready, output, 1, meaning a free tile buffer exists.
REQ-009 SHALL have port out_data, output, SEG_W, the current segment.
REQ-010 SHALL have port out_valid, output, 1, and port out_ready, input, 1, forming a valid/ready handshake.
REQ-011 SHALL have port out_last, output, 1, meaning the current beat is the final segment of its tile.
REQ-012 SHALL have port out_idx, output, 5, the segment index of the current beat.
REQ-013 SHALL have port ovf, output, 1, a sticky overflow flag, and port ovf_cnt, output, 8, a saturating drop count.
REQ-014 SHALL have port clr_ovf, input, 1, which synchronously clears ovf and ovf_cnt.

Function
REQ-015 SHALL hold two tile buffers (B0, B1), each with a full flag and a latched segment count NSEG.
REQ-016 SHALL hold write pointer wp, read pointer rp and segment counter seg, 5 bits.
REQ-017 SHALL set NSEG to 4*A*16/SEG_W (32 at defaults) when in_mode[1]=1, and to A*16/(2*SEG_W) (4 at defaults) otherwise.
REQ-018 SHALL drive in_ready = !full[wp] from registered state only, with no combinational path from in_valid.
REQ-019 SHALL, on in_valid && in_ready, capture in_data and NSEG into B[wp], set full[wp] and toggle wp at that edge.
REQ-020 SHALL, on in_valid && !in_ready, discard the tile, set ovf, and increment ovf_cnt, saturating at 255.
REQ-021 SHALL, if clr_ovf and a drop occur in the same cycle, give priority to the drop: ovf=1, ovf_cnt=1.
REQ-022 SHALL drive out_valid = full[rp], out_data = segment seg of B[rp], out_idx = seg, and out_last = out_valid && (seg == NSEG[rp]-1).
REQ-023 SHALL hold out_data, out_idx and out_last stable while out_valid && !out_ready.
REQ-024 SHALL, on out_valid && out_ready with !out_last, increment seg.
REQ-025 SHALL, on out_valid && out_ready with out_last, clear full[rp], toggle rp and set seg=0.
REQ-026 SHALL take 1 cycle from accept to first beat: a tile accepted at edge N into an empty block gives out_valid=1 after edge N.
REQ-027 SHALL handle accept into B[wp] and release of B[rp] in the same cycle independently; in_ready observes the released buffer as free only from the next cycle.
REQ-028 SHALL emit buffers strictly in acceptance order, and emit back-to-back tiles with no bubble when out_ready stays 1.
REQ-029 SHALL never modify a buffer while it is full.

Reset
REQ-030 SHALL, while rst=1, force full[0]=full[1]=0, wp=rp=0, seg=0, ovf=0 and ovf_cnt=0.
REQ-031 SHALL, while rst=1, hold out_valid=0, out_last=0, out_idx=0 and in_ready=1; buffer contents are don't-care and out_data is 0.
REQ-032 SHALL, on rst asserted mid-drain, immediately (asynchronously) abandon the in-flight tile; no beat of it appears after release.

Verification
REQ-033 Upsample tile, segment k = {8{16'h0100+k}}, out_ready=1 -> 32 beats over 32 consecutive cycles, out_idx 0..31, out_last only on beat 31, data matches.
REQ-034 Downsample tile (in_mode=2'b00) -> exactly 4 beats, out_last on out_idx=3, segments 4..31 never emitted.
REQ-035 out_ready=0 with three tiles pulsed on consecutive cycles -> first two accepted, in_ready=0 after the second, third dropped, ovf=1, ovf_cnt=1; releasing out_ready drains tiles 1 then 2 in order.
REQ-036 out_ready toggling 1,0,1,0 during an upsample drain -> each beat held unchanged while stalled, 32 beats total, no skip or duplicate.
REQ-037 260 drops, then clr_ovf -> ovf_cnt saturates at 255, then reads ovf=0 and ovf_cnt=0.
REQ-038 rst pulsed at beat 10 of an upsample drain -> out_valid=0 immediately; a new downsample tile after release drains 4 beats starting at out_idx=0.
